rob_banked: RTL and testbench

ROB_BANKED -- requirements
Module: rob_banked

---
 rtl/rob_banked_pkg.sv | 25 ++
 rtl/rob_banked_youngest_match.sv | 23 ++
 rtl/rob_banked.sv | 207 ++++++++++++++++++++
 tb/tb_rob_banked.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_banked_pkg.sv
// rtl/rob_banked_pkg.sv - shared constants and entry type for the banked reorder buffer
package rob_banked_pkg;

  localparam int ROB_ROWS_DEF = 16;
  localparam int BANKS_DEF    = 2;
  localparam int WB_PORTS_DEF = 2;
  localparam int PREG_W_DEF   = 6;
  // Widest physical register tag an entry can hold; instances use the low PREG_W bits.
  localparam int PREG_W_MAX   = 16;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  is_br;
    logic [PREG_W_MAX-1:0] phys_rd;
    logic [4:0]            arch_rd;
    logic [31:0]           pc;
  } rob_banked_entry_t;

  // Bank index width, never narrower than one bit.
  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/rob_banked_youngest_match.sv
// rtl/rob_banked_youngest_match.sv - finds the youngest matching entry in an age-ordered vector
module rob_youngest_match #(
  parameter int N = 32
) (
  input  logic [N-1:0] match,
  input  logic [N-1:0] done,
  output logic         hit,
  output logic         hit_done
);

  // Index 0 is oldest; the last matching index seen is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (match[i]) begin
        hit      = 1'b1;
        hit_done = done[i];
      end
    end
  end

endmodule

// File: rtl/rob_banked.sv
// rtl/rob_banked.sv - row-banked reorder buffer with writeback, commit, squash and operand readiness
module rob_banked
  import rob_banked_pkg::*;
#(
  parameter  int ROB_ROWS = ROB_ROWS_DEF,
  parameter  int BANKS    = BANKS_DEF,
  parameter  int WB_PORTS = WB_PORTS_DEF,
  parameter  int PREG_W   = PREG_W_DEF,
  localparam int ROW_W    = $clog2(ROB_ROWS),
  localparam int BANK_W   = bank_w(BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BANKS-1:0]            disp_valid,
  input  logic [BANKS*PREG_W-1:0]     disp_phys_rd,
  input  logic [BANKS*5-1:0]          disp_arch_rd,
  input  logic [BANKS*32-1:0]         disp_pc,
  input  logic [BANKS-1:0]            disp_is_br,
  output logic                        disp_ready,
  output logic [ROW_W-1:0]            disp_row,
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [WB_PORTS*ROW_W-1:0]   wb_row,
  input  logic [WB_PORTS*BANK_W-1:0]  wb_bank,
  input  logic [WB_PORTS-1:0]         wb_mispredict,
  input  logic [2*BANKS*PREG_W-1:0]   src_phys,
  output logic [2*BANKS-1:0]          src_ready,
  output logic [BANKS-1:0]            cm_valid,
  output logic [BANKS*PREG_W-1:0]     cm_phys_rd,
  output logic [BANKS*5-1:0]          cm_arch_rd,
  output logic [BANKS*32-1:0]         cm_pc,
  output logic                        squash_valid
);

  localparam int N    = ROB_ROWS * BANKS;
  localparam int NSRC = 2 * BANKS;
  localparam logic [ROW_W:0] FULL = (ROW_W+1)'(ROB_ROWS);

  rob_banked_entry_t rob_q [ROB_ROWS][BANKS];
  rob_banked_entry_t rob_d [ROB_ROWS][BANKS];

  logic [ROW_W-1:0]               head, tail, head_d, tail_d;
  logic [ROW_W:0]                 count, count_d;
  logic                           commit_fire, disp_fire, mp_any;
  logic [ROW_W-1:0]               mp_row;
  logic [BANK_W-1:0]              mp_bank;
  logic [BANKS-1:0]               head_valid;
  logic [ROB_ROWS-1:0][BANKS-1:0] wb_hit;
  logic [N-1:0]                   src_match [NSRC];
  logic [N-1:0]                   src_done  [NSRC];

  // Decode every writeback port into a per-entry hit map (out-of-range banks ignored).
  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && (int'(wb_bank[p*BANK_W +: BANK_W]) < BANKS))
        wb_hit[wb_row[p*ROW_W +: ROW_W]][wb_bank[p*BANK_W +: BANK_W]] = 1'b1;
    end
  end

  // Lowest-index mispredicting port wins.
  always_comb begin
    mp_any  = |wb_mispredict;
    mp_row  = '0;
    mp_bank = '0;
    for (int p = WB_PORTS-1; p >= 0; p--) begin
      if (wb_mispredict[p]) begin
        mp_row  = wb_row[p*ROW_W +: ROW_W];
        mp_bank = wb_bank[p*BANK_W +: BANK_W];
      end
    end
  end

  // Head row retires once every valid entry was already done at the start of the cycle.
  always_comb begin
    head_valid  = '0;
    commit_fire = (count != '0);
    for (int b = 0; b < BANKS; b++) begin
      head_valid[b] = rob_q[head][b].valid;
      if (rob_q[head][b].valid && !rob_q[head][b].done)
        commit_fire = 1'b0;
    end
  end

  assign disp_ready = (count < FULL) && !mp_any;
  assign disp_row   = tail;
  assign disp_fire  = disp_ready && (|disp_valid);

  // Next entry state: writeback, then squash, then commit clear, then dispatch.
  always_comb begin
    logic [ROW_W-1:0] mp_dist;
    logic [ROW_W-1:0] e_dist;
    int               mp_age;
    rob_d   = rob_q;
    mp_dist = mp_row - head;
    mp_age  = int'(mp_dist) * BANKS + int'(mp_bank);
    e_dist  = '0;
    for (int r = 0; r < ROB_ROWS; r++) begin
      for (int b = 0; b < BANKS; b++) begin
        if (wb_hit[r][b] && rob_q[r][b].valid)
          rob_d[r][b].done = 1'b1;
        e_dist = ROW_W'(r) - head;
        if (mp_any && ((int'(e_dist) * BANKS + b) > mp_age)) begin
          rob_d[r][b].valid = 1'b0;
          rob_d[r][b].done  = 1'b0;
        end
      end
    end
    if (commit_fire) begin
      for (int b = 0; b < BANKS; b++)
        rob_d[head][b] = '0;
    end
    if (disp_fire) begin
      for (int b = 0; b < BANKS; b++)
        rob_d[tail][b] = '{valid:   disp_valid[b],
                           done:    1'b0,
                           is_br:   disp_is_br[b],
                           phys_rd: PREG_W_MAX'(disp_phys_rd[b*PREG_W +: PREG_W]),
                           arch_rd: disp_arch_rd[b*5 +: 5],
                           pc:      disp_pc[b*32 +: 32]};
    end
  end

  // Pointer update; a squash rebuilds tail and occupancy from the branch row.
  always_comb begin
    logic [ROW_W-1:0] keep_dist;
    keep_dist = mp_row - head;
    head_d    = head + ROW_W'(commit_fire);
    if (mp_any) begin
      tail_d  = mp_row + ROW_W'(1);
      count_d = (ROW_W+1)'(keep_dist) + (ROW_W+1)'(1) - (ROW_W+1)'(commit_fire);
    end else begin
      tail_d  = tail + ROW_W'(disp_fire);
      count_d = count + (ROW_W+1)'(disp_fire) - (ROW_W+1)'(commit_fire);
    end
  end

  // Entry array and pointers; reset discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROB_ROWS; r++)
        for (int b = 0; b < BANKS; b++)
          rob_q[r][b] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      rob_q <= rob_d;
      head  <= head_d;
      tail  <= tail_d;
      count <= count_d;
    end
  end

  // Registered commit and squash outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cm_valid     <= '0;
      cm_phys_rd   <= '0;
      cm_arch_rd   <= '0;
      cm_pc        <= '0;
      squash_valid <= 1'b0;
    end else begin
      squash_valid <= mp_any;
      cm_valid     <= commit_fire ? head_valid : '0;
      if (commit_fire) begin
        for (int b = 0; b < BANKS; b++) begin
          cm_phys_rd[b*PREG_W +: PREG_W] <= rob_q[head][b].phys_rd[PREG_W-1:0];
          cm_arch_rd[b*5 +: 5]           <= rob_q[head][b].arch_rd;
          cm_pc[b*32 +: 32]              <= rob_q[head][b].pc;
        end
      end
    end
  end

  // Lay entries out oldest-first so the finder can pick the youngest match.
  always_comb begin
    logic [ROW_W-1:0] row;
    int               bk;
    row = '0;
    bk  = 0;
    for (int s = 0; s < NSRC; s++) begin
      src_match[s] = '0;
      src_done[s]  = '0;
    end
    for (int a = 0; a < N; a++) begin
      row = head + ROW_W'(a / BANKS);
      bk  = a % BANKS;
      for (int s = 0; s < NSRC; s++) begin
        src_match[s][a] = rob_q[row][bk].valid &&
                          (rob_q[row][bk].phys_rd[PREG_W-1:0] == src_phys[s*PREG_W +: PREG_W]);
        src_done[s][a]  = rob_q[row][bk].done || wb_hit[row][bk];
      end
    end
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic hit, hit_done;
    rob_youngest_match #(.N(N)) u_match (
      .match    (src_match[s]),
      .done     (src_done[s]),
      .hit      (hit),
      .hit_done (hit_done)
    );
    assign src_ready[s] = (src_phys[s*PREG_W +: PREG_W] == '0) || !hit || hit_done;
  end

endmodule

// File: tb/tb_rob_banked.sv
// tb/tb_rob_banked.sv - self-checking bench for rob_banked against a row-queue reference model
module tb_rob_banked;

  localparam int R = 16;
  localparam int B = 2;
  localparam int W = 2;
  localparam int P = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [B-1:0]     disp_valid, disp_is_br;
  logic [B*P-1:0]   disp_phys_rd;
  logic [B*5-1:0]   disp_arch_rd;
  logic [B*32-1:0]  disp_pc;
  logic             disp_ready;
  logic [3:0]       disp_row;
  logic [W-1:0]     wb_valid, wb_mispredict;
  logic [W*4-1:0]   wb_row;
  logic [W-1:0]     wb_bank;
  logic [2*B*P-1:0] src_phys;
  logic [2*B-1:0]   src_ready;
  logic [B-1:0]     cm_valid;
  logic [B*P-1:0]   cm_phys_rd;
  logic [B*5-1:0]   cm_arch_rd;
  logic [B*32-1:0]  cm_pc;
  logic             squash_valid;

  logic [3:0]   x_disp_valid, x_disp_is_br;
  logic [23:0]  x_disp_phys_rd;
  logic [19:0]  x_disp_arch_rd;
  logic [127:0] x_disp_pc;
  logic         x_disp_ready;
  logic [3:0]   x_disp_row;
  logic [2:0]   x_wb_valid, x_wb_mispredict;
  logic [11:0]  x_wb_row;
  logic [5:0]   x_wb_bank;
  logic [47:0]  x_src_phys;
  logic [7:0]   x_src_ready;
  logic [3:0]   x_cm_valid;
  logic [23:0]  x_cm_phys_rd;
  logic [19:0]  x_cm_arch_rd;
  logic [127:0] x_cm_pc;
  logic         x_squash_valid;

  rob_banked dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_phys_rd(disp_phys_rd), .disp_arch_rd(disp_arch_rd),
    .disp_pc(disp_pc), .disp_is_br(disp_is_br), .disp_ready(disp_ready), .disp_row(disp_row),
    .wb_valid(wb_valid), .wb_row(wb_row), .wb_bank(wb_bank), .wb_mispredict(wb_mispredict),
    .src_phys(src_phys), .src_ready(src_ready),
    .cm_valid(cm_valid), .cm_phys_rd(cm_phys_rd), .cm_arch_rd(cm_arch_rd), .cm_pc(cm_pc),
    .squash_valid(squash_valid)
  );

  rob_banked #(.ROB_ROWS(16), .BANKS(4), .WB_PORTS(3), .PREG_W(6)) dut4 (
    .clk(clk), .rst(rst),
    .disp_valid(x_disp_valid), .disp_phys_rd(x_disp_phys_rd), .disp_arch_rd(x_disp_arch_rd),
    .disp_pc(x_disp_pc), .disp_is_br(x_disp_is_br), .disp_ready(x_disp_ready), .disp_row(x_disp_row),
    .wb_valid(x_wb_valid), .wb_row(x_wb_row), .wb_bank(x_wb_bank), .wb_mispredict(x_wb_mispredict),
    .src_phys(x_src_phys), .src_ready(x_src_ready),
    .cm_valid(x_cm_valid), .cm_phys_rd(x_cm_phys_rd), .cm_arch_rd(x_cm_arch_rd), .cm_pc(x_cm_pc),
    .squash_valid(x_squash_valid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight rows oldest-first; m_head is the row index of the front.
  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  dn;
    logic [11:0] ph;
    logic [9:0]  ar;
    logic [63:0] pc;
  } mrow_t;

  mrow_t       mq[$];
  int          m_head;
  logic [1:0]  e_cm_v;
  logic [11:0] e_cm_ph;
  logic [9:0]  e_cm_ar;
  logic [63:0] e_cm_pc;
  logic        e_sq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    disp_valid = '0; disp_is_br = '0; disp_phys_rd = '0; disp_arch_rd = '0; disp_pc = '0;
    wb_valid = '0; wb_mispredict = '0; wb_row = '0; wb_bank = '0;
  endtask

  task automatic set_disp(input logic [1:0] v, input logic [5:0] p0, input logic [5:0] p1,
                          input logic [1:0] br);
    disp_valid   = v;
    disp_phys_rd = {p1, p0};
    disp_arch_rd = 10'($urandom);
    disp_pc      = {$urandom, $urandom};
    disp_is_br   = br;
  endtask

  task automatic set_wb(input int p, input int row, input int bank, input bit mp);
    wb_valid[p]      = 1'b1;
    wb_row[p*4 +: 4] = 4'(row);
    wb_bank[p]       = 1'(bank);
    wb_mispredict[p] = mp;
  endtask

  // Youngest in-flight producer decides readiness; a same-cycle writeback counts as done.
  function automatic bit m_src_ready(input int s);
    logic [5:0] ph;
    bit rdy;
    ph = src_phys[s*P +: P];
    if (ph == 6'd0) return 1'b1;
    for (int k = mq.size() - 1; k >= 0; k--) begin
      for (int b = B - 1; b >= 0; b--) begin
        if (mq[k].v[b] && (mq[k].ph[b*P +: P] == ph)) begin
          rdy = mq[k].dn[b];
          for (int p = 0; p < W; p++)
            if (wb_valid[p] && (wb_row[p*4 +: 4] == 4'((m_head + k) % R)) && (wb_bank[p] == 1'(b)))
              rdy = 1'b1;
          return rdy;
        end
      end
    end
    return 1'b1;
  endfunction

  task automatic step();
    bit    exp_rdy, commit;
    int    mp, k, bb;
    mrow_t t;
    #1;
    exp_rdy = (mq.size() < R) && (wb_mispredict == '0);
    chk("disp_ready", disp_ready, exp_rdy);
    chk("disp_row", disp_row, 64'((m_head + mq.size()) % R));
    for (int s = 0; s < 2*B; s++)
      chk($sformatf("src_ready%0d", s), src_ready[s], m_src_ready(s));
    commit = (mq.size() > 0) && ((mq[0].v & ~mq[0].dn) == 2'b00);
    e_cm_v = 2'b00;
    if (commit) begin
      e_cm_v = mq[0].v; e_cm_ph = mq[0].ph; e_cm_ar = mq[0].ar; e_cm_pc = mq[0].pc;
    end
    for (int p = 0; p < W; p++) begin
      if (wb_valid[p]) begin
        k = (int'(wb_row[p*4 +: 4]) - m_head + R) % R;
        bb = int'(wb_bank[p]);
        if (k < mq.size()) begin
          t = mq[k];
          if (t.v[bb]) t.dn[bb] = 1'b1;
          mq[k] = t;
        end
      end
    end
    mp = -1;
    for (int p = W - 1; p >= 0; p--) if (wb_mispredict[p]) mp = p;
    if (mp >= 0) begin
      k = (int'(wb_row[mp*4 +: 4]) - m_head + R) % R;
      bb = int'(wb_bank[mp]);
      while (mq.size() > k + 1) void'(mq.pop_back());
      if (k < mq.size()) begin
        t = mq[k];
        for (int b = bb + 1; b < B; b++) begin t.v[b] = 1'b0; t.dn[b] = 1'b0; end
        mq[k] = t;
      end
    end
    if (commit) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % R;
    end
    if (exp_rdy && (disp_valid != '0))
      mq.push_back('{v: disp_valid, dn: 2'b00, ph: disp_phys_rd, ar: disp_arch_rd, pc: disp_pc});
    e_sq = (mp >= 0);
    @(posedge clk);
    #1;
    chk("cm_valid", cm_valid, e_cm_v);
    for (int b = 0; b < B; b++) begin
      if (e_cm_v[b]) begin
        chk("cm_phys_rd", cm_phys_rd[b*P +: P], e_cm_ph[b*P +: P]);
        chk("cm_arch_rd", cm_arch_rd[b*5 +: 5], e_cm_ar[b*5 +: 5]);
        chk("cm_pc", cm_pc[b*32 +: 32], e_cm_pc[b*32 +: 32]);
      end
    end
    chk("squash_valid", squash_valid, e_sq);
    chk("count", dut.count, 64'(mq.size()));
    clr_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_in();
    mq.delete();
    m_head = 0;
    #1;
    chk("rst_cm_valid", cm_valid, 0);
    chk("rst_cm_phys", cm_phys_rd, 0);
    chk("rst_cm_pc", cm_pc, 0);
    chk("rst_squash", squash_valid, 0);
    chk("rst_count", dut.count, 0);
    chk("rst_disp_row", disp_row, 0);
    chk("rst_disp_ready", disp_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k, bb;
    clr_in();
    src_phys = '0;
    x_disp_valid = '0; x_disp_is_br = '0; x_disp_phys_rd = '0; x_disp_arch_rd = '0; x_disp_pc = '0;
    x_wb_valid = '0; x_wb_mispredict = '0; x_wb_row = '0; x_wb_bank = '0; x_src_phys = '0;
    rst = 1'b1;

    // reset wins over a dispatch presented in the same cycle
    set_disp(2'b11, 6'd1, 6'd2, 2'b00);
    do_reset();

    // fill all 16 rows with bank0 only, no writeback
    for (int i = 0; i < 16; i++) begin
      set_disp(2'b01, 6'(i + 1), 6'd0, 2'b00);
      step();
    end
    chk("full_disp_ready", disp_ready, 0);
    chk("full_count", dut.count, 16);
    set_disp(2'b01, 6'd7, 6'd0, 2'b00);
    step();

    // reset mid-operation drops everything
    do_reset();
    src_phys[5:0] = 6'd1;

    // two-bank row commits only after both banks are done
    set_disp(2'b11, 6'd5, 6'd6, 2'b00);
    step();
    set_wb(0, 0, 1, 1'b0);
    step();
    chk("partial_no_commit", cm_valid, 0);
    set_wb(0, 0, 0, 1'b0);
    step();
    step();
    chk("pair_cm_valid", cm_valid, 2'b11);
    chk("pair_cm_phys", cm_phys_rd, {6'd6, 6'd5});

    // branch at row1 bank0 mispredicts
    do_reset();
    set_disp(2'b11, 6'd10, 6'd11, 2'b00); step();
    set_disp(2'b11, 6'd12, 6'd20, 2'b01); step();
    set_disp(2'b11, 6'd21, 6'd22, 2'b00); step();
    set_disp(2'b11, 6'd23, 6'd24, 2'b00); step();
    src_phys = {6'd21, 6'd23, 6'd20, 6'd12};
    #1;
    chk("pre_squash_b1_pending", src_ready[1], 0);
    set_wb(0, 1, 0, 1'b1);
    #1;
    chk("mp_blocks_dispatch", disp_ready, 0);
    step();
    chk("squash_pulse", squash_valid, 1);
    chk("squash_tail", disp_row, 2);
    chk("squash_count", dut.count, 2);
    chk("squash_row1_b1_gone", src_ready[1], 1);
    chk("squash_row3_gone", src_ready[2], 1);
    step();
    chk("squash_pulse_end", squash_valid, 0);

    // youngest producer decides readiness, with same-cycle bypass
    do_reset();
    src_phys = '0;
    set_disp(2'b01, 6'd9, 6'd0, 2'b00); step();
    set_disp(2'b01, 6'd3, 6'd0, 2'b00); step();
    set_disp(2'b01, 6'd9, 6'd0, 2'b00); step();
    set_wb(0, 0, 0, 1'b0);
    step();
    src_phys[5:0] = 6'd9;
    #1;
    chk("src_youngest_pending", src_ready[0], 0);
    set_wb(1, 2, 0, 1'b0);
    #1;
    chk("src_bypass", src_ready[0], 1);
    step();

    // wraparound: head 15, tail 3, then commit and dispatch together
    do_reset();
    src_phys = '0;
    for (int i = 0; i < 17; i++) begin
      if (i < 15) set_disp(2'b01, 6'(i + 1), 6'd0, 2'b00);
      if (i >= 1 && i <= 15) set_wb(0, i - 1, 0, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_disp(2'b01, 6'(30 + i), 6'd0, 2'b00);
      step();
    end
    set_wb(0, 15, 0, 1'b0);
    step();
    chk("wrap_head_before", dut.head, 15);
    chk("wrap_tail_before", disp_row, 3);
    chk("wrap_count_before", dut.count, 4);
    set_disp(2'b01, 6'd40, 6'd0, 2'b00);
    step();
    chk("wrap_count_after", dut.count, 4);
    chk("wrap_tail_after", disp_row, 4);
    chk("wrap_head_after", dut.head, 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0)
        set_disp(2'($urandom_range(1, 3)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                 2'($urandom));
      for (int p = 0; p < W; p++)
        if ((mq.size() > 0) && ($urandom_range(0, 2) == 0))
          set_wb(p, (m_head + $urandom_range(0, mq.size() - 1)) % R, $urandom_range(0, 1), 1'b0);
      if ((mq.size() > 1) && ($urandom_range(0, 19) == 0)) begin
        k  = $urandom_range(0, mq.size() - 1);
        bb = $urandom_range(0, 1);
        if (mq[k].v[bb] && !mq[k].dn[bb])
          set_wb($urandom_range(0, 1), (m_head + k) % R, bb, 1'b1);
      end
      for (int s = 0; s < 2*B; s++)
        src_phys[s*P +: P] = 6'($urandom_range(0, 7));
      step();
    end

    // four-bank, three-port build: port0 and port2 mispredict together
    do_reset();
    for (int r = 0; r < 4; r++) begin
      x_disp_valid = 4'hf;
      for (int b = 0; b < 4; b++)
        x_disp_phys_rd[b*6 +: 6] = 6'(8 + r*4 + b);
      @(posedge clk);
      #1;
    end
    x_disp_valid    = '0;
    x_wb_valid      = 3'b101;
    x_wb_mispredict = 3'b101;
    x_wb_row        = {4'd2, 4'd0, 4'd1};
    x_wb_bank       = {2'd3, 2'd0, 2'd1};
    x_src_phys[5:0]  = 6'd14;
    x_src_phys[11:6] = 6'd12;
    #1;
    chk("b4_mp_blocks_dispatch", x_disp_ready, 0);
    @(posedge clk);
    #1;
    x_wb_valid = '0;
    x_wb_mispredict = '0;
    #1;
    chk("b4_squash", x_squash_valid, 1);
    chk("b4_tail_port0", x_disp_row, 2);
    chk("b4_count", dut4.count, 2);
    chk("b4_row1_b2_squashed", x_src_ready[0], 1);
    chk("b4_row1_b0_kept", x_src_ready[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
